// File: rtl/issue_queue_dual_pkg.sv
// Shared types for the dual-issue queue: uop type encoding and the packed queue entry.
package issue_queue_dual_pkg;

  localparam int unsigned WIDTH_UOP     = 16;
  localparam int unsigned UOP_TYPE_LSB  = 0;
  localparam int unsigned UOP_TYPE_W    = 8;
  localparam int unsigned ITYPE_IDX_ALU = 0;

  typedef struct packed {
    logic [WIDTH_UOP-1:0] uop;
    logic [4:0]           rd;
    logic [4:0]           rj;
    logic [4:0]           rk;
    logic [31:0]          pc;
    logic [31:0]          pc_next;
    logic [31:0]          imm;
    logic [6:0]           exp;
  } issue_entry_t;

  localparam int unsigned ISSUE_ENTRY_W = $bits(issue_entry_t);

  // Uop type field is one-hot; eu1 only accepts the ALU class.
  function automatic logic is_alu(input logic [WIDTH_UOP-1:0] uop);
    logic [UOP_TYPE_W-1:0] t;
    t = uop[UOP_TYPE_LSB +: UOP_TYPE_W];
    return t[ITYPE_IDX_ALU];
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register in-flight writer counters (r1..r31) with two issue increments and two
// writeback decrements per cycle.
module issue_scoreboard #(
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        inc0_en,
  input  logic [4:0]  inc0_addr,
  input  logic        inc1_en,
  input  logic [4:0]  inc1_addr,
  input  logic        dec0_en,
  input  logic [4:0]  dec0_addr,
  input  logic        dec1_en,
  input  logic [4:0]  dec1_addr,
  output logic [31:0] busy,
  output logic [31:0] sat,
  output logic [31:0] sat_m1
);

  localparam int unsigned CW = CNT_W + 2;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_MAX_M1 = CNT_MAX - CNT_W'(1);

  logic [31:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                   underflow;

  always_comb begin
    logic [CW-1:0] inc_w, dec_w, sum_w;
    inc_w     = '0;
    dec_w     = '0;
    sum_w     = '0;
    cnt_d     = cnt_q;
    underflow = 1'b0;
    // r0 is never counted: the loop starts at 1 and cnt_q[0] only ever resets to zero.
    for (int unsigned r = 1; r < 32; r++) begin
      inc_w = CW'(inc0_en && inc0_addr == 5'(r)) + CW'(inc1_en && inc1_addr == 5'(r));
      dec_w = CW'(dec0_en && dec0_addr == 5'(r)) + CW'(dec1_en && dec1_addr == 5'(r));
      sum_w = CW'(cnt_q[r]) + inc_w;
      if (sum_w < dec_w) underflow = 1'b1;
      cnt_d[r] = CNT_W'(sum_w - dec_w);
    end
  end

  always_comb begin
    busy   = '0;
    sat    = '0;
    sat_m1 = '0;
    for (int unsigned r = 0; r < 32; r++) begin
      busy[r]   = cnt_q[r] != '0;
      sat[r]    = cnt_q[r] == CNT_MAX;
      sat_m1[r] = cnt_q[r] == CNT_MAX_M1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      cnt_q <= '0;
    end else begin
      assert (!underflow);
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_queue_dual.sv
// In-order dual-issue queue: circular uop buffer, RAW hazard check against the
// writer scoreboard, and eu0 (any type) / eu1 (ALU only) issue lanes.
module issue_queue_dual
  import issue_queue_dual_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 stall,
  input  logic                 dec0_valid,
  input  logic [WIDTH_UOP-1:0] dec0_uop,
  input  logic [4:0]           dec0_rd,
  input  logic [4:0]           dec0_rj,
  input  logic [4:0]           dec0_rk,
  input  logic [31:0]          dec0_pc,
  input  logic [31:0]          dec0_pc_next,
  input  logic [31:0]          dec0_imm,
  input  logic [6:0]           dec0_exp,
  input  logic                 dec1_valid,
  input  logic [WIDTH_UOP-1:0] dec1_uop,
  input  logic [4:0]           dec1_rd,
  input  logic [4:0]           dec1_rj,
  input  logic [4:0]           dec1_rk,
  input  logic [31:0]          dec1_pc,
  input  logic [31:0]          dec1_pc_next,
  input  logic [31:0]          dec1_imm,
  input  logic [6:0]           dec1_exp,
  output logic                 dec_ready,
  input  logic                 write_en_0,
  input  logic [4:0]           write_addr_0,
  input  logic                 write_en_1,
  input  logic [4:0]           write_addr_1,
  output logic                 eu0_en_out,
  output logic [WIDTH_UOP-1:0] eu0_uop_out,
  output logic [4:0]           eu0_rd_out,
  output logic [4:0]           eu0_rj_out,
  output logic [4:0]           eu0_rk_out,
  output logic [31:0]          eu0_pc_out,
  output logic [31:0]          eu0_pc_next_out,
  output logic [31:0]          eu0_imm_out,
  output logic [6:0]           eu0_exp_out,
  output logic                 eu1_en_out,
  output logic [WIDTH_UOP-1:0] eu1_uop_out,
  output logic [4:0]           eu1_rd_out,
  output logic [4:0]           eu1_rj_out,
  output logic [4:0]           eu1_rk_out,
  output logic [31:0]          eu1_pc_out,
  output logic [31:0]          eu1_pc_next_out,
  output logic [31:0]          eu1_imm_out,
  output logic [6:0]           eu1_exp_out
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [ISSUE_ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d, head1, tail1;
  logic [PTR_W:0]           count_q, count_d, n_push, n_iss;
  issue_entry_t             head_e, next_e, dec0_e, dec1_e, lane0, lane1;
  logic [31:0]              busy, sat, sat_m1;
  logic                     push, iss0, iss1;

  function automatic logic hazard(input issue_entry_t e, input logic [31:0] bz,
                                  input logic [31:0] st);
    return bz[e.rj] | bz[e.rk] | st[e.rd];
  endfunction

  assign head1  = head_q + PTR_W'(1);
  assign tail1  = tail_q + PTR_W'(1);
  assign head_e = issue_entry_t'(mem_q[head_q]);
  assign next_e = issue_entry_t'(mem_q[head1]);
  assign dec0_e = '{dec0_uop, dec0_rd, dec0_rj, dec0_rk, dec0_pc, dec0_pc_next, dec0_imm, dec0_exp};
  assign dec1_e = '{dec1_uop, dec1_rd, dec1_rj, dec1_rk, dec1_pc, dec1_pc_next, dec1_imm, dec1_exp};

  assign dec_ready = count_q <= (PTR_W+1)'(DEPTH - 2);

  always_comb begin
    eu0_en_out = (count_q != '0) && !hazard(head_e, busy, sat);
    // eu1 also avoids an intra-pair RAW on head.rd and a WAW pair that would overflow cnt[rd].
    eu1_en_out = eu0_en_out && (count_q >= (PTR_W+1)'(2)) &&
                 (head_e.exp == '0) && (next_e.exp == '0) && is_alu(next_e.uop) &&
                 !hazard(next_e, busy, sat) &&
                 !((head_e.rd != '0) && ((next_e.rj == head_e.rd) || (next_e.rk == head_e.rd))) &&
                 !((head_e.rd != '0) && (next_e.rd == head_e.rd) && sat_m1[head_e.rd]);
  end

  assign iss0   = eu0_en_out && !stall && !flush;
  assign iss1   = eu1_en_out && !stall && !flush;
  assign push   = dec_ready && dec0_valid && !flush;
  assign n_push = push ? (dec1_valid ? (PTR_W+1)'(2) : (PTR_W+1)'(1)) : '0;
  assign n_iss  = (PTR_W+1)'(iss0) + (PTR_W+1)'(iss1);

  always_comb begin
    head_d  = head_q + PTR_W'(n_iss);
    tail_d  = tail_q + PTR_W'(n_push);
    count_d = count_q + n_push - n_iss;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[tail_q] <= dec0_e;
    if (push && dec1_valid) mem_q[tail1] <= dec1_e;
  end

  issue_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .inc0_en  (iss0 && (head_e.exp == '0)),
    .inc0_addr(head_e.rd),
    .inc1_en  (iss1),
    .inc1_addr(next_e.rd),
    .dec0_en  (write_en_0),
    .dec0_addr(write_addr_0),
    .dec1_en  (write_en_1),
    .dec1_addr(write_addr_1),
    .busy     (busy),
    .sat      (sat),
    .sat_m1   (sat_m1)
  );

  assign lane0 = eu0_en_out ? head_e : '0;
  assign lane1 = eu1_en_out ? next_e : '0;

  assign eu0_uop_out     = lane0.uop;
  assign eu0_rd_out      = lane0.rd;
  assign eu0_rj_out      = lane0.rj;
  assign eu0_rk_out      = lane0.rk;
  assign eu0_pc_out      = lane0.pc;
  assign eu0_pc_next_out = lane0.pc_next;
  assign eu0_imm_out     = lane0.imm;
  assign eu0_exp_out     = lane0.exp;
  assign eu1_uop_out     = lane1.uop;
  assign eu1_rd_out      = lane1.rd;
  assign eu1_rj_out      = lane1.rj;
  assign eu1_rk_out      = lane1.rk;
  assign eu1_pc_out      = lane1.pc;
  assign eu1_pc_next_out = lane1.pc_next;
  assign eu1_imm_out     = lane1.imm;
  assign eu1_exp_out     = lane1.exp;

endmodule

// File: tb/tb_issue_queue_dual.sv
// Directed bench for issue_queue_dual: pushed uops go into an expected-issue queue
// and are popped and compared in order whenever a lane issues.
module tb_issue_queue_dual;
  import issue_queue_dual_pkg::*;

  localparam logic [WIDTH_UOP-1:0] UOP_ALU  = 16'h0001;
  localparam logic [WIDTH_UOP-1:0] UOP_LOAD = 16'h0002;

  logic                 clk = 1'b0;
  logic                 rstn, flush, stall;
  logic                 dec0_valid, dec1_valid;
  logic [WIDTH_UOP-1:0] dec0_uop, dec1_uop;
  logic [4:0]           dec0_rd, dec0_rj, dec0_rk, dec1_rd, dec1_rj, dec1_rk;
  logic [31:0]          dec0_pc, dec0_pc_next, dec0_imm, dec1_pc, dec1_pc_next, dec1_imm;
  logic [6:0]           dec0_exp, dec1_exp;
  logic                 dec_ready;
  logic                 write_en_0, write_en_1;
  logic [4:0]           write_addr_0, write_addr_1;
  logic                 eu0_en_out, eu1_en_out;
  logic [WIDTH_UOP-1:0] eu0_uop_out, eu1_uop_out;
  logic [4:0]           eu0_rd_out, eu0_rj_out, eu0_rk_out, eu1_rd_out, eu1_rj_out, eu1_rk_out;
  logic [31:0]          eu0_pc_out, eu0_pc_next_out, eu0_imm_out;
  logic [31:0]          eu1_pc_out, eu1_pc_next_out, eu1_imm_out;
  logic [6:0]           eu0_exp_out, eu1_exp_out;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [6:0]  exp;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] pc_ctr   = 32'h1000;

  always #5 clk = ~clk;

  issue_queue_dual #(.DEPTH(8), .CNT_W(2)) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
    .dec0_valid(dec0_valid), .dec0_uop(dec0_uop), .dec0_rd(dec0_rd), .dec0_rj(dec0_rj),
    .dec0_rk(dec0_rk), .dec0_pc(dec0_pc), .dec0_pc_next(dec0_pc_next), .dec0_imm(dec0_imm),
    .dec0_exp(dec0_exp),
    .dec1_valid(dec1_valid), .dec1_uop(dec1_uop), .dec1_rd(dec1_rd), .dec1_rj(dec1_rj),
    .dec1_rk(dec1_rk), .dec1_pc(dec1_pc), .dec1_pc_next(dec1_pc_next), .dec1_imm(dec1_imm),
    .dec1_exp(dec1_exp),
    .dec_ready(dec_ready),
    .write_en_0(write_en_0), .write_addr_0(write_addr_0),
    .write_en_1(write_en_1), .write_addr_1(write_addr_1),
    .eu0_en_out(eu0_en_out), .eu0_uop_out(eu0_uop_out), .eu0_rd_out(eu0_rd_out),
    .eu0_rj_out(eu0_rj_out), .eu0_rk_out(eu0_rk_out), .eu0_pc_out(eu0_pc_out),
    .eu0_pc_next_out(eu0_pc_next_out), .eu0_imm_out(eu0_imm_out), .eu0_exp_out(eu0_exp_out),
    .eu1_en_out(eu1_en_out), .eu1_uop_out(eu1_uop_out), .eu1_rd_out(eu1_rd_out),
    .eu1_rj_out(eu1_rj_out), .eu1_rk_out(eu1_rk_out), .eu1_pc_out(eu1_pc_out),
    .eu1_pc_next_out(eu1_pc_next_out), .eu1_imm_out(eu1_imm_out), .eu1_exp_out(eu1_exp_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] cnt(input int r);
    return 32'(dut.u_sb.cnt_q[r]);
  endfunction

  task automatic set0(input logic alu, input logic [4:0] rd, input logic [4:0] rj,
                      input logic [4:0] rk, input logic [6:0] exp, input logic track);
    dec0_valid = 1'b1; dec0_uop = alu ? UOP_ALU : UOP_LOAD;
    dec0_rd = rd; dec0_rj = rj; dec0_rk = rk; dec0_exp = exp;
    dec0_pc = pc_ctr; dec0_pc_next = pc_ctr + 32'd4; dec0_imm = pc_ctr ^ 32'h55;
    if (track) sb.push_back('{pc_ctr, rd, exp});
    pc_ctr += 32'd4;
  endtask

  task automatic set1(input logic alu, input logic [4:0] rd, input logic [4:0] rj,
                      input logic [4:0] rk, input logic [6:0] exp, input logic track);
    dec1_valid = 1'b1; dec1_uop = alu ? UOP_ALU : UOP_LOAD;
    dec1_rd = rd; dec1_rj = rj; dec1_rk = rk; dec1_exp = exp;
    dec1_pc = pc_ctr; dec1_pc_next = pc_ctr + 32'd4; dec1_imm = pc_ctr ^ 32'h55;
    if (track) sb.push_back('{pc_ctr, rd, exp});
    pc_ctr += 32'd4;
  endtask

  task automatic pop_chk(input string lane, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] pcn, input logic [6:0] exp);
    exp_t e;
    if (sb.size() == 0) begin
      chk({lane, "_unexpected_issue"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk({lane, "_pc"}, pc, e.pc);
      chk({lane, "_rd"}, 32'(rd), 32'(e.rd));
      chk({lane, "_pc_next"}, pcn, e.pc + 32'd4);
      chk({lane, "_exp"}, 32'(exp), 32'(e.exp));
    end
  endtask

  task automatic half();
    @(negedge clk);
    if (!stall && !flush) begin
      if (eu0_en_out) pop_chk("eu0", eu0_pc_out, eu0_rd_out, eu0_pc_next_out, eu0_exp_out);
      if (eu1_en_out) pop_chk("eu1", eu1_pc_out, eu1_rd_out, eu1_pc_next_out, eu1_exp_out);
    end
    if (!eu1_en_out) chk("eu1_idle_pc_zero", eu1_pc_out, 32'd0);
  endtask

  task automatic fin();
    @(posedge clk);
    #1;
    dec0_valid = 1'b0; dec1_valid = 1'b0;
    write_en_0 = 1'b0; write_en_1 = 1'b0;
    flush = 1'b0;
  endtask

  task automatic cyc();
    half();
    fin();
  endtask

  initial begin
    logic nz;
    rstn = 1'b0; flush = 1'b0; stall = 1'b0;
    dec0_valid = 1'b0; dec1_valid = 1'b0;
    dec0_uop = '0; dec0_rd = '0; dec0_rj = '0; dec0_rk = '0;
    dec0_pc = '0; dec0_pc_next = '0; dec0_imm = '0; dec0_exp = '0;
    dec1_uop = '0; dec1_rd = '0; dec1_rj = '0; dec1_rk = '0;
    dec1_pc = '0; dec1_pc_next = '0; dec1_imm = '0; dec1_exp = '0;
    write_en_0 = 1'b0; write_en_1 = 1'b0; write_addr_0 = '0; write_addr_1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_eu0_en", 32'(eu0_en_out), 32'd0);
    chk("rst_eu1_en", 32'(eu1_en_out), 32'd0);
    chk("rst_dec_ready", 32'(dec_ready), 32'd1);
    chk("rst_count", 32'(dut.count_q), 32'd0);
    chk("rst_eu0_pc_zero", eu0_pc_out, 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Independent ALU pair issues together the cycle after the push.
    set0(1'b1, 5'd3, 5'd1, 5'd2, 7'd0, 1'b1);
    set1(1'b1, 5'd4, 5'd5, 5'd6, 7'd0, 1'b1);
    half(); chk("t1_no_bypass", 32'(eu0_en_out), 32'd0); fin();
    half();
    chk("t1_eu0_en", 32'(eu0_en_out), 32'd1);
    chk("t1_eu1_en", 32'(eu1_en_out), 32'd1);
    fin();
    chk("t1_cnt3", cnt(3), 32'd1);
    chk("t1_cnt4", cnt(4), 32'd1);
    write_en_0 = 1'b1; write_addr_0 = 5'd3; write_en_1 = 1'b1; write_addr_1 = 5'd4;
    cyc();
    chk("t1_cnt3_wb", cnt(3), 32'd0);
    chk("t1_cnt4_wb", cnt(4), 32'd0);

    // RAW: r5<-r3 waits for the r3 writeback and issues the cycle after it.
    set0(1'b1, 5'd3, 5'd1, 5'd0, 7'd0, 1'b1);
    set1(1'b1, 5'd5, 5'd3, 5'd0, 7'd0, 1'b1);
    cyc();
    half();
    chk("t2_eu0_en", 32'(eu0_en_out), 32'd1);
    chk("t2_eu1_raw_block", 32'(eu1_en_out), 32'd0);
    fin();
    half(); chk("t2_wait_hazard", 32'(eu0_en_out), 32'd0); fin();
    write_en_0 = 1'b1; write_addr_0 = 5'd3;
    half(); chk("t2_wb_cycle_still_blocked", 32'(eu0_en_out), 32'd0); fin();
    half(); chk("t2_after_wb_issue", 32'(eu0_en_out), 32'd1); fin();
    chk("t2_cnt5", cnt(5), 32'd1);
    write_en_0 = 1'b1; write_addr_0 = 5'd5;
    cyc();

    // Non-ALU next entry cannot use eu1.
    set0(1'b1, 5'd6, 5'd1, 5'd2, 7'd0, 1'b1);
    set1(1'b0, 5'd7, 5'd1, 5'd2, 7'd0, 1'b1);
    cyc();
    half();
    chk("t3_eu0_en", 32'(eu0_en_out), 32'd1);
    chk("t3_load_not_eu1", 32'(eu1_en_out), 32'd0);
    fin();
    half(); chk("t3_load_on_eu0", 32'(eu0_en_out), 32'd1); fin();
    write_en_0 = 1'b1; write_addr_0 = 5'd6; write_en_1 = 1'b1; write_addr_1 = 5'd7;
    cyc();
    chk("t3_count_empty", 32'(dut.count_q), 32'd0);

    // Fill under stall, hold, then drain two per cycle.
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set0(1'b1, 5'(8 + 2*k), 5'd0, 5'd0, 7'd0, 1'b1);
      set1(1'b1, 5'(9 + 2*k), 5'd0, 5'd0, 7'd0, 1'b1);
      half(); chk("t4_dec_ready_fill", 32'(dec_ready), 32'd1); fin();
    end
    chk("t4_count_full", 32'(dut.count_q), 32'd8);
    half();
    chk("t4_dec_ready_full", 32'(dec_ready), 32'd0);
    chk("t4_stall_lane_valid", 32'(eu0_en_out), 32'd1);
    chk("t4_stall_head_pc", eu0_pc_out, sb[0].pc);
    fin();
    chk("t4_stall_count_hold", 32'(dut.count_q), 32'd8);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      half();
      chk("t4_drain_eu0", 32'(eu0_en_out), 32'd1);
      chk("t4_drain_eu1", 32'(eu1_en_out), 32'd1);
      fin();
    end
    chk("t4_drained", 32'(dut.count_q), 32'd0);
    chk("t4_dec_ready_again", 32'(dec_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      write_en_0 = 1'b1; write_addr_0 = 5'(8 + 2*k);
      write_en_1 = 1'b1; write_addr_1 = 5'(9 + 2*k);
      cyc();
    end

    // Excepting head issues alone and is not counted.
    set0(1'b1, 5'd9, 5'd0, 5'd0, 7'h08, 1'b1);
    set1(1'b1, 5'd10, 5'd0, 5'd0, 7'd0, 1'b1);
    cyc();
    half();
    chk("t5_exp_eu0", 32'(eu0_en_out), 32'd1);
    chk("t5_exp_alone", 32'(eu1_en_out), 32'd0);
    fin();
    chk("t5_cnt9_not_counted", cnt(9), 32'd0);
    half(); fin();
    chk("t5_cnt10", cnt(10), 32'd1);
    write_en_0 = 1'b1; write_addr_0 = 5'd10;
    cyc();

    // Flush with entries queued, cnt[7]=2, plus simultaneous push and writeback.
    set0(1'b1, 5'd7, 5'd0, 5'd0, 7'd0, 1'b1);
    set1(1'b1, 5'd7, 5'd0, 5'd0, 7'd0, 1'b1);
    cyc();
    half(); chk("t6_waw_pair_eu1", 32'(eu1_en_out), 32'd1); fin();
    chk("t6_cnt7_two", cnt(7), 32'd2);
    stall = 1'b1;
    set0(1'b1, 5'd0, 5'd1, 5'd2, 7'd0, 1'b1); set1(1'b1, 5'd0, 5'd1, 5'd2, 7'd0, 1'b1); cyc();
    set0(1'b1, 5'd0, 5'd1, 5'd2, 7'd0, 1'b1); set1(1'b1, 5'd0, 5'd1, 5'd2, 7'd0, 1'b1); cyc();
    set0(1'b1, 5'd0, 5'd1, 5'd2, 7'd0, 1'b1); cyc();
    chk("t6_count_five", 32'(dut.count_q), 32'd5);
    flush = 1'b1;
    set0(1'b1, 5'd11, 5'd0, 5'd0, 7'd0, 1'b0);
    write_en_0 = 1'b1; write_addr_0 = 5'd7;
    cyc();
    sb.delete();
    stall = 1'b0;
    chk("t6_count_zero", 32'(dut.count_q), 32'd0);
    chk("t6_cnt7_zero", cnt(7), 32'd0);
    nz = 1'b0;
    for (int r = 0; r < 32; r++) nz = nz | (cnt(r) != 32'd0);
    chk("t6_all_cnt_zero", 32'(nz), 32'd0);
    half();
    chk("t6_eu0_off", 32'(eu0_en_out), 32'd0);
    chk("t6_dec_ready", 32'(dec_ready), 32'd1);
    fin();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
